// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared types and defaults for the counter command sequencer: command
// opcodes, FSM state encoding and the acceptance-time next-state decode.
package counter_cmd_sequencer_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_EVT_W  = 8;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'd0,
      OP_UP     = 2'd1,
      OP_DOWN   = 2'd2,
      OP_SETMAX = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } seq_state_e;

   // State entered right after a command is accepted. SETMAX and zero-length
   // runs have nothing to drive, so they report completion immediately.
   function automatic seq_state_e accept_state(input cmd_op_e op, input logic arg_zero);
      seq_state_e ns;
      case (op)
         OP_LOAD:   ns = S_LOAD;
         OP_SETMAX: ns = S_DONE;
         default:   ns = arg_zero ? S_DONE : S_RUN;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Command handshake bundle between a command source (master) and the
// counter command sequencer (slave).
interface counter_cmd_sequencer_if
   import counter_cmd_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   cmd_op_e           cmd_op;
   logic [DATA_W-1:0] cmd_arg;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_arg,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_arg,
      output cmd_ready
   );

endinterface

// File: rtl/counter_cmd_sequencer_run_timer.sv
// Run-length timer: holds the number of enable cycles still to issue for an
// UP/DOWN run and flags the final one.
module seq_run_timer
   import counter_cmd_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_val,
   input  logic              dec,
   input  logic              clr,
   output logic              last
);

   logic [DATA_W-1:0] remaining;

   // Load the run length at acceptance, drop to zero on abort, count down per enable cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= load_val;
      end else if (clr) begin
         remaining <= '0;
      end else if (dec && (remaining != '0)) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign last = (remaining == DATA_W'(1));

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Counter command sequencer: accepts LOAD/UP/DOWN/SETMAX commands and turns
// them into cycle-exact load/enable/up_down/max_count drive for a
// programmable counter, reporting completion and per-run tc/zero statistics.
// Every output is a flop; the drive flops are loaded from the state being
// entered so they line up exactly with the FSM state.
module counter_cmd_sequencer
   import counter_cmd_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int EVT_W  = DEF_EVT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   counter_cmd_sequencer_if.slave  cmd_if,
   input  logic                    abort,
   output logic                    cnt_load,
   output logic                    cnt_enable,
   output logic                    cnt_up_down,
   output logic [DATA_W-1:0]       cnt_load_value,
   output logic [DATA_W-1:0]       cnt_max_count,
   input  logic                    cnt_tc,
   input  logic                    cnt_zero,
   output logic                    done,
   output logic                    aborted,
   output logic [EVT_W-1:0]        tc_events,
   output logic                    zero_seen
);

   seq_state_e state_q;
   seq_state_e state_d;
   logic       ready_q;
   logic       accept;
   logic       run_cmd;
   logic       run_start;
   logic       abort_run;
   logic       run_last;

   // Saturating increment for the tc statistic.
   function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign cmd_if.cmd_ready = ready_q;
   assign accept    = cmd_if.cmd_valid && ready_q;
   assign run_cmd   = (cmd_if.cmd_op == OP_UP) || (cmd_if.cmd_op == OP_DOWN);
   assign run_start = accept && run_cmd;
   // abort only has meaning while enable cycles are being issued
   assign abort_run = (state_q == S_RUN) && abort;

   seq_run_timer #(
      .DATA_W   (DATA_W)
   ) u_run_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (run_start),
      .load_val (cmd_if.cmd_arg),
      .dec      (state_q == S_RUN),
      .clr      (abort_run),
      .last     (run_last)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; IDLE and DONE both accept, which gives back-to-back issue.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = accept_state(cmd_if.cmd_op, cmd_if.cmd_arg == '0);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: state_d = S_DONE;
         S_RUN: begin
            if (abort || run_last) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and counter strobes, registered from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q    <= 1'b1;
         cnt_load   <= 1'b0;
         cnt_enable <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         ready_q    <= (state_d == S_IDLE) || (state_d == S_DONE);
         cnt_load   <= (state_d == S_LOAD);
         cnt_enable <= (state_d == S_RUN);
         done       <= (state_d == S_DONE);
         aborted    <= abort_run;
      end
   end

   // Command payload captured at acceptance; held until a command of the same kind replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_up_down    <= 1'b0;
         cnt_load_value <= '0;
         cnt_max_count  <= '1;
      end else if (accept) begin
         case (cmd_if.cmd_op)
            OP_LOAD:   cnt_load_value <= cmd_if.cmd_arg;
            OP_UP:     cnt_up_down    <= 1'b1;
            OP_DOWN:   cnt_up_down    <= 1'b0;
            OP_SETMAX: cnt_max_count  <= cmd_if.cmd_arg;
            default:   ;
         endcase
      end
   end

   // Run statistics: cleared when a run starts, accumulated only on enable cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc_events <= '0;
         zero_seen <= 1'b0;
      end else if (run_start) begin
         tc_events <= '0;
         zero_seen <= 1'b0;
      end else if (cnt_enable) begin
         if (cnt_tc) begin
            tc_events <= sat_inc(tc_events);
         end
         if (cnt_zero) begin
            zero_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer driving a behavioural programmable counter.
// Each issued command pushes its expected completion record; the monitor pops
// and compares it on the done pulse.
module tb_counter_cmd_sequencer;
   import counter_cmd_sequencer_pkg::*;

   localparam int DATA_W = 8;
   localparam int EVT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              abort;
   logic              cnt_load;
   logic              cnt_enable;
   logic              cnt_up_down;
   logic [DATA_W-1:0] cnt_load_value;
   logic [DATA_W-1:0] cnt_max_count;
   logic              cnt_tc;
   logic              cnt_zero;
   logic              done;
   logic              aborted;
   logic [EVT_W-1:0]  tc_events;
   logic              zero_seen;
   logic [DATA_W-1:0] count;

   counter_cmd_sequencer_if #(.DATA_W(DATA_W)) cmd_if ();

   counter_cmd_sequencer #(
      .DATA_W         (DATA_W),
      .EVT_W          (EVT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_if         (cmd_if),
      .abort          (abort),
      .cnt_load       (cnt_load),
      .cnt_enable     (cnt_enable),
      .cnt_up_down    (cnt_up_down),
      .cnt_load_value (cnt_load_value),
      .cnt_max_count  (cnt_max_count),
      .cnt_tc         (cnt_tc),
      .cnt_zero       (cnt_zero),
      .done           (done),
      .aborted        (aborted),
      .tc_events      (tc_events),
      .zero_seen      (zero_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural programmable counter: wraps to 0 above max going up, to max below 0 going down.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (cnt_load) begin
         count <= cnt_load_value;
      end else if (cnt_enable) begin
         if (cnt_up_down) count <= (count >= cnt_max_count) ? '0 : count + 1'b1;
         else             count <= (count == '0) ? cnt_max_count : count - 1'b1;
      end
   end
   assign cnt_tc   = cnt_up_down ? (count == cnt_max_count) : (count == '0);
   assign cnt_zero = (count == '0);

   typedef struct {
      int lat;
      int enables;
      int loads;
      bit aborted;
      int tc;
      bit zero;
      int count;
      bit dir;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run = 0;
   int   fail_cnt  = 0;

   // reference state of the counter and statistics, advanced per issued command
   int m_count = 0;
   int m_max   = 255;
   int m_tc    = 0;
   bit m_zero  = 0;
   bit m_dir   = 0;

   // monitor state
   bit mon_active = 0;
   bit mon_dir = 0;
   int mon_cyc = 0, mon_en = 0, mon_ld = 0, mon_dirbad = 0, mon_rdybusy = 0, mon_overlap = 0;
   int b2b_accepts = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor: counts per-command activity and scores it on the done pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 0;
      end else begin
         if (mon_active) begin
            mon_cyc++;
            if (cnt_enable) begin
               mon_en++;
               if (cnt_up_down != mon_dir) mon_dirbad++;
            end
            if (cnt_load) mon_ld++;
            if (cnt_load && cnt_enable) mon_overlap++;
            if (cmd_if.cmd_ready && !done) mon_rdybusy++;
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               check_val("spurious_done", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_val("latency",        mon_cyc,            e.lat);
               check_val("enable_cycles",  mon_en,             e.enables);
               check_val("load_cycles",    mon_ld,             e.loads);
               check_val("aborted",        32'(aborted),       32'(e.aborted));
               check_val("tc_events",      32'(tc_events),     e.tc);
               check_val("zero_seen",      32'(zero_seen),     32'(e.zero));
               check_val("count",          32'(count),         e.count);
               check_val("up_down_stable", mon_dirbad,         0);
               check_val("ready_busy",     mon_rdybusy,        0);
               check_val("load_en_overlap", mon_overlap,       0);
            end
            mon_active = 0;
         end
         if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (done) b2b_accepts++;
            mon_active  = 1;
            mon_cyc     = 0;
            mon_en      = 0;
            mon_ld      = 0;
            mon_dirbad  = 0;
            mon_rdybusy = 0;
            mon_overlap = 0;
            mon_dir     = (sb_q.size() != 0) ? sb_q[0].dir : 1'b0;
         end
      end
   end

   task automatic check_reset_outputs();
      check_val("rst_cmd_ready",   32'(cmd_if.cmd_ready), 1);
      check_val("rst_cnt_load",    32'(cnt_load),         0);
      check_val("rst_cnt_enable",  32'(cnt_enable),       0);
      check_val("rst_cnt_up_down", 32'(cnt_up_down),      0);
      check_val("rst_load_value",  32'(cnt_load_value),   0);
      check_val("rst_max_count",   32'(cnt_max_count),    255);
      check_val("rst_done",        32'(done),             0);
      check_val("rst_aborted",     32'(aborted),          0);
      check_val("rst_tc_events",   32'(tc_events),        0);
      check_val("rst_zero_seen",   32'(zero_seen),        0);
   endtask

   // Push the expected outcome, present the command and wait for its acceptance edge.
   // Called #1 after a rising edge; returns #1 after the acceptance edge (or after abort).
   task automatic issue(input cmd_op_e op, input int arg, input int ab, input bit keep);
      exp_t e;
      int   steps;
      bit   got;
      e = '{default: 0};
      case (op)
         OP_LOAD: begin
            m_count = arg;
            e.lat = 2;
            e.loads = 1;
         end
         OP_SETMAX: begin
            m_max = arg;
            e.lat = 1;
         end
         default: begin
            m_tc   = 0;
            m_zero = 0;
            m_dir  = (op == OP_UP);
            e.aborted = (ab > 0) && (ab < arg);
            steps = e.aborted ? ab : arg;
            for (int i = 0; i < steps; i++) begin
               if (m_dir ? (m_count == m_max) : (m_count == 0)) begin
                  if (m_tc < 255) m_tc++;
               end
               if (m_count == 0) m_zero = 1;
               if (m_dir) m_count = (m_count >= m_max) ? 0 : m_count + 1;
               else       m_count = (m_count == 0) ? m_max : m_count - 1;
            end
            e.enables = steps;
            e.lat = steps + 1;
         end
      endcase
      e.tc = m_tc;
      e.zero = m_zero;
      e.count = m_count;
      e.dir = m_dir;
      sb_q.push_back(e);

      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_arg   = arg[DATA_W-1:0];
      got = 0;
      for (int n = 0; n < 500 && !got; n++) begin
         @(negedge clk);
         got = cmd_if.cmd_ready;
      end
      if (!got) check_val("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (!keep) cmd_if.cmd_valid = 1'b0;
      if (e.aborted) begin
         repeat (ab - 1) @(posedge clk);
         #1;
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check_val("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input cmd_op_e op, input int arg, input int ab);
      issue(op, arg, ab, 1'b0);
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
      $fatal(1, "watchdog");
   end

   initial begin
      int b2b0;
      bit got;
      rst_n            = 1'b0;
      abort            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = OP_LOAD;
      cmd_if.cmd_arg   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: SETMAX 10, LOAD 7
      run_one(OP_SETMAX, 10, 0);
      check_val("max_count_10", 32'(cnt_max_count), 10);
      run_one(OP_LOAD, 7, 0);

      // 2: LOAD 5 with abort held (must be ignored), then UP 12 wrapping once
      abort = 1'b1;
      run_one(OP_LOAD, 5, 0);
      abort = 1'b0;
      run_one(OP_UP, 12, 0);

      // 3: DOWN 8 from 6 passes through zero
      run_one(OP_DOWN, 8, 0);

      // 4: zero-length run, then long run aborted in its third enable cycle
      run_one(OP_UP, 0, 0);
      run_one(OP_UP, 200, 3);

      // 5: four commands with cmd_valid held throughout
      b2b0 = b2b_accepts;
      issue(OP_SETMAX, 15, 0, 1'b1);
      issue(OP_LOAD,    3, 0, 1'b1);
      issue(OP_UP,      4, 0, 1'b1);
      issue(OP_DOWN,    2, 0, 1'b0);
      drain();
      check_val("b2b_accepts", b2b_accepts - b2b0, 3);

      // 6: reset in the middle of a run
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = OP_UP;
      cmd_if.cmd_arg   = 8'd100;
      got = 0;
      for (int n = 0; n < 500 && !got; n++) begin
         @(negedge clk);
         got = cmd_if.cmd_ready;
      end
      if (!got) check_val("accept_timeout_rst", 0, 1);
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_val("run_active_before_rst", 32'(cnt_enable), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      m_count = 0;
      m_max   = 255;
      m_tc    = 0;
      m_zero  = 0;
      m_dir   = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // recovery after reset: max back to 255, down-run wraps to it
      run_one(OP_LOAD, 4, 0);
      run_one(OP_DOWN, 5, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
